// File: rtl/mix_columns_engine_pkg.sv
// Shared AES GF(2^8) helpers for the MixColumns datapath.
//   - aes_col_t       : one 32-bit state column, first byte in the MSBs
//   - GF_POLY         : low byte of the field polynomial x^8+x^4+x^3+x+1
//   - MC_FWD / MC_INV : mode select values
//   - xtime, gf_mul2/3/9/11/13/14 : constant multipliers built from xtime and XOR
package aes_pkg;

    typedef logic [31:0] aes_col_t;

    localparam logic [7:0] GF_POLY = 8'h1B;
    localparam logic       MC_FWD  = 1'b0;
    localparam logic       MC_INV  = 1'b1;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns of a single 32-bit column.
//   i_col : input column (a0 in bits [31:24])
//   i_inv : MC_FWD = (2,3,1,1), MC_INV = (14,11,13,9)
//   o_col : transformed column, same byte layout
module mix_column_word
    import aes_pkg::*;
(
    input  aes_col_t i_col,
    input  logic     i_inv,
    output aes_col_t o_col
);

    logic [7:0] w_a [4];
    logic [7:0] w_r [4];

    genvar r;
    generate
        for (r = 0; r < 4; r++) begin : g_row
            assign w_a[r] = i_col[31-8*r -: 8];
            // Row r uses the coefficient row rotated by r.
            assign w_r[r] = (i_inv == MC_INV)
                ? (gf_mul14(w_a[r]) ^ gf_mul11(w_a[(r+1)%4]) ^
                   gf_mul13(w_a[(r+2)%4]) ^ gf_mul9(w_a[(r+3)%4]))
                : (gf_mul2(w_a[r]) ^ gf_mul3(w_a[(r+1)%4]) ^
                   w_a[(r+2)%4] ^ w_a[(r+3)%4]);
        end
    endgenerate

    assign o_col = {w_r[0], w_r[1], w_r[2], w_r[3]};

endmodule

// File: rtl/mix_columns_engine.sv
// Handshaked AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns
// per clock (1, 2 or 4), so one 128-bit state takes 4, 2 or 1 BUSY cycles.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : input handshake; in_state/in_inv (and in_skip)
//                          are latched on acceptance
//   out_valid / out_ready: output handshake; out_state held while out_valid
// Optional macro MIXCOL_SKIP_EN adds in_skip: a latched 1 passes the state
// through unchanged with the same latency and handshake.
module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
`ifdef MIXCOL_SKIP_EN
    input  logic         in_skip,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
            $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // log2(COLS_PER_CYCLE): column index = (grp << SH) | slot.
    localparam int         SH       = (COLS_PER_CYCLE == 4) ? 2 : ((COLS_PER_CYCLE == 2) ? 1 : 0);
    localparam logic [1:0] LAST_GRP = 2'((4 >> SH) - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t       r_state, w_state_nxt;
    logic [127:0] r_lat;
    logic         r_inv;
    logic         r_skip;
    logic [1:0]   r_grp;
    logic [127:0] r_out_state;
    logic         w_accept;

    aes_col_t w_lat_cols [4];
    aes_col_t w_out_cols [4];
    aes_col_t w_col_in   [COLS_PER_CYCLE];
    aes_col_t w_col_out  [COLS_PER_CYCLE];
    aes_col_t w_res      [COLS_PER_CYCLE];

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign out_state = r_out_state;
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept)            w_state_nxt = S_BUSY;
            S_BUSY:  if (r_grp == LAST_GRP)   w_state_nxt = S_DONE;
            S_DONE:  if (out_ready)           w_state_nxt = S_IDLE;
            default:                          w_state_nxt = S_IDLE;
        endcase
    end

    genvar k, c;
    generate
        for (k = 0; k < COLS_PER_CYCLE; k++) begin : g_slot
            logic [1:0] w_idx;
            assign w_idx       = (r_grp << SH) | 2'(k);
            assign w_col_in[k] = w_lat_cols[w_idx];

            mix_column_word u_mc (
                .i_col (w_col_in[k]),
                .i_inv (r_inv),
                .o_col (w_col_out[k])
            );

`ifdef MIXCOL_SKIP_EN
            assign w_res[k] = r_skip ? w_col_in[k] : w_col_out[k];
`else
            assign w_res[k] = w_col_out[k];
`endif
        end

        // Each result column is rewritten only in the BUSY cycle of its own group.
        for (c = 0; c < 4; c++) begin : g_col
            localparam logic [1:0] CGRP = 2'(c >> SH);
            localparam int         SLOT = c % COLS_PER_CYCLE;
            assign w_lat_cols[c] = r_lat[127-32*c -: 32];
            assign w_out_cols[c] = (r_state == S_BUSY && r_grp == CGRP)
                                   ? w_res[SLOT] : r_out_state[127-32*c -: 32];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lat       <= '0;
            r_inv       <= MC_FWD;
            r_skip      <= 1'b0;
            r_grp       <= '0;
            r_out_state <= '0;
        end else begin
            r_out_state <= {w_out_cols[0], w_out_cols[1], w_out_cols[2], w_out_cols[3]};
            if (w_accept) begin
                r_lat  <= in_state;
                r_inv  <= in_inv;
`ifdef MIXCOL_SKIP_EN
                r_skip <= in_skip;
`else
                r_skip <= 1'b0;
`endif
                r_grp  <= '0;
            end else if (r_state == S_BUSY) begin
                r_grp <= (r_grp == LAST_GRP) ? 2'd0 : r_grp + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Self-checking bench: three engines (COLS_PER_CYCLE = 4, 2, 1) share one
// stimulus stream and are checked against a polynomial-reduction GF model.
module tb_mix_columns_engine;

    localparam int NI = 3;
`ifdef MIXCOL_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_inv, in_skip, out_ready;
    logic [127:0] in_state;
    logic         in_ready_w  [NI];
    logic         out_valid_w [NI];
    logic [127:0] out_state_w [NI];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            localparam int CPC = 4 >> g;
            mix_columns_engine #(.COLS_PER_CYCLE(CPC)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (in_ready_w[g]),
                .in_state  (in_state),
                .in_inv    (in_inv),
`ifdef MIXCOL_SKIP_EN
                .in_skip   (in_skip),
`endif
                .out_valid (out_valid_w[g]),
                .out_ready (out_ready),
                .out_state (out_state_w[g])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Carry-less multiply then reduce modulo 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input int unsigned k);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (k[i]) p ^= 16'(a) << i;
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011B << (i - 8);
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] x, input logic inv);
        int unsigned  cf [4];
        logic [7:0]   a  [4];
        logic [7:0]   b;
        logic [127:0] y;
        if (inv) cf = '{14, 11, 13, 9};
        else     cf = '{2, 3, 1, 1};
        y = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = x[127-32*c-8*r -: 8];
            for (int r = 0; r < 4; r++) begin
                b = '0;
                for (int j = 0; j < 4; j++) b ^= gmul(a[(r+j)%4], cf[j]);
                y[127-32*c-8*r -: 8] = b;
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (!(in_ready_w[0] && in_ready_w[1] && in_ready_w[2]) && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        if (cyc >= 20) check({tag, " ready timeout"}, 0, 1);
    endtask

    // Entered just after the acceptance edge T; checks latency and result.
    task automatic wait_done(input string tag, input logic [127:0] exp);
        int cyc;
        int lat  [NI];
        bit seen [NI];
        for (int i = 0; i < NI; i++) begin lat[i] = -1; seen[i] = 1'b0; end
        cyc = 0;
        forever begin
            for (int i = 0; i < NI; i++)
                if (out_valid_w[i] && !seen[i]) begin seen[i] = 1'b1; lat[i] = cyc; end
            if ((seen[0] && seen[1] && seen[2]) || cyc >= 10) break;
            @(posedge clk); #1; cyc++;
        end
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s lat cpc%0d", tag, 4 >> i), 128'(lat[i]), 128'(1 << i));
            check($sformatf("%s data cpc%0d", tag, 4 >> i), out_state_w[i], exp);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic accept(input logic [127:0] x, input logic inv, input logic skip);
        in_valid = 1'b1; in_state = x; in_inv = inv; in_skip = skip;
        @(posedge clk); #1;
        // Scramble inputs: the engine must work from its latched copy.
        in_valid = 1'b0; in_state = rand128(); in_inv = ~inv; in_skip = ~skip;
    endtask

    task automatic run_txn(input string tag, input logic [127:0] x, input logic inv,
                           input logic skip, output logic [127:0] got);
        logic [127:0] exp;
        exp = (SKIP_EN && skip) ? x : ref_mix(x, inv);
        wait_ready(tag);
        accept(x, inv, skip);
        wait_done(tag, exp);
        got = out_state_w[0];
        release_out();
    endtask

    initial begin
        logic [127:0] x, y, z, snap;
        rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_skip = 1'b0;
        out_ready = 1'b0; in_state = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst in_ready %0d", i), 128'(in_ready_w[i]), 0);
            check($sformatf("rst out_valid %0d", i), 128'(out_valid_w[i]), 0);
            check($sformatf("rst out_state %0d", i), out_state_w[i], '0);
        end
        rst = 1'b0; #1;
        for (int i = 0; i < NI; i++)
            check($sformatf("post-rst in_ready %0d", i), 128'(in_ready_w[i]), 1);

        // Known vectors.
        x = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        run_txn("kv fwd", x, 1'b0, 1'b0, y);
        check("kv fwd const", y, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        run_txn("kv inv", y, 1'b1, 1'b0, z);
        check("kv inv const", z, x);
        run_txn("kv2 fwd", 128'hd4d4d4d5_2d26314c_00000000_00000000, 1'b0, 1'b0, y);
        check("kv2 fwd const", y, 128'hd5d5d7d6_4d7ebdf8_00000000_00000000);

        // Skip path (transformed when the option is compiled out).
        run_txn("skip", 128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 1'b1, y);

        // Backpressure: hold DONE for 10 cycles with a new request pending.
        x = rand128();
        y = rand128();
        wait_ready("bp");
        accept(x, 1'b0, 1'b0);
        wait_done("bp first", ref_mix(x, 1'b0));
        snap = ref_mix(x, 1'b0);
        in_valid = 1'b1; in_state = y; in_inv = 1'b1; in_skip = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                check($sformatf("bp valid c%0d i%0d", n, i), 128'(out_valid_w[i]), 1);
                check($sformatf("bp hold c%0d i%0d", n, i), out_state_w[i], snap);
                check($sformatf("bp ready c%0d i%0d", n, i), 128'(in_ready_w[i]), 0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("bp idle ready %0d", i), 128'(in_ready_w[i]), 1);
            check($sformatf("bp idle valid %0d", i), 128'(out_valid_w[i]), 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_state = rand128(); in_inv = 1'b0;
        wait_done("bp second", ref_mix(y, 1'b1));
        release_out();

        // Reset in BUSY after two groups of the 1-column engine.
        wait_ready("rst busy");
        accept(rand128(), 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1; #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("abort valid %0d", i), 128'(out_valid_w[i]), 0);
            check($sformatf("abort state %0d", i), out_state_w[i], '0);
            check($sformatf("abort ready %0d", i), 128'(in_ready_w[i]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_txn("after abort", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0, y);

        // Random round trips.
        for (int n = 0; n < 1000; n++) begin
            x = rand128();
            run_txn("rnd fwd", x, 1'b0, 1'b0, y);
            run_txn("rnd inv", y, 1'b1, 1'b0, z);
            check("rnd roundtrip", z, x);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
